// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection and a circular return-address stack
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic [CW-1:0]   ras_count,
  output logic            misalign,
  output logic            ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, misalign_d, underflow_q, underflow_d;
  logic            has, push, repl, pop;
  assign has      = count_q != '0;
  assign top_idx  = ptr_q - 1'b1;
  // call+ret on an empty stack degenerates to a plain push
  assign push     = !stall && call && (!ret || !has);
  assign repl     = !stall && call && ret && has;
  assign pop      = !stall && ret && !call && has;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign ras_top  = has ? ras_q[top_idx] : '0;
  assign pc            = pc_q;
  assign ras_count     = count_q;
  assign misalign      = misalign_q;
  assign ras_underflow = underflow_q;
  always_comb begin
    pc_d        = redirect_valid ? {redirect_target[XLEN-1:2], 2'b00} :
                  stall ? pc_q : (ret && has) ? ras_top : pc_plus4;
    misalign_d  = redirect_valid ? |redirect_target[1:0] : misalign_q;
    underflow_d = !stall && ret && !call && !has;
    ptr_d       = push ? ptr_q + 1'b1 : pop ? top_idx : ptr_q;
    count_d     = push ? ((count_q == FULL) ? count_q : count_q + 1'b1) :
                  pop ? count_q - 1'b1 : count_q;
    ras_d       = ras_q;
    if (push || repl) ras_d[push ? ptr_q : top_idx] = pc_plus4;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      ptr_q       <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
      ras_q       <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
      ras_q       <= ras_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of next-PC priority, RAS push/pop/overflow and wrap-around
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc, pc_plus4, ras_top;
  logic [2:0]  ras_count;
  logic        misalign, ras_underflow;
  int passed = 0;
  int total = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call(call), .ret(ret), .pc(pc),
    .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_count(ras_count),
    .misalign(misalign), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic s, input logic rv, input logic [31:0] t, input logic c, input logic r);
    stall = s; redirect_valid = rv; redirect_target = t; call = c; ret = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else passed++;
    total++; if (ras_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", ras_count); else passed++;
    total++; if ({misalign, ras_underflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {misalign, ras_underflow}); else passed++;
    total++; if (ras_top !== 32'h0) $display("FAIL reset_top: got %h expected 0", ras_top); else passed++;
    total++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pcp4: got %h expected 4", pc_plus4); else passed++;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0);
      total++; if (pc !== 32'(4 * i)) $display("FAIL freerun_%0d: got %h expected %h", i, pc, 32'(4 * i)); else passed++;
    end
    #2 reset = 1'b1;
    #1;
    total++; if (pc !== 32'h0) $display("FAIL async_reset: got %h expected 0", pc); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_redirect_stall;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    total++; if (pc !== 32'h8) $display("FAIL pre_stall: got %h expected 8", pc); else passed++;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    total++; if (pc !== 32'h8) $display("FAIL stall_hold: got %h expected 8", pc); else passed++;
    total++; if (ras_count !== 3'd0) $display("FAIL stall_call_ignored: got %0d expected 0", ras_count); else passed++;
    step(1, 1, 32'h100, 0, 0);
    total++; if (pc !== 32'h100) $display("FAIL redirect_over_stall: got %h expected 100", pc); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", misalign); else passed++;
    step(0, 1, 32'h203, 0, 0);
    total++; if (pc !== 32'h200) $display("FAIL redirect_align: got %h expected 200", pc); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL misalign_set: got %b expected 1", misalign); else passed++;
    step(0, 0, 0, 0, 0);
    total++; if ({pc, misalign} !== {32'h204, 1'b1}) $display("FAIL misalign_hold: got %h/%b expected 204/1", pc, misalign); else passed++;
    step(1, 1, 32'h300, 0, 0);
    total++; if ({pc, misalign} !== {32'h300, 1'b0}) $display("FAIL misalign_update: got %h/%b expected 300/0", pc, misalign); else passed++;
  endtask

  task automatic test_call_ret;
    step(0, 1, 32'h10, 0, 0);
    step(0, 1, 32'h80, 1, 0);
    total++; if (pc !== 32'h80) $display("FAIL call_pc: got %h expected 80", pc); else passed++;
    total++; if (ras_top !== 32'h14) $display("FAIL call_top: got %h expected 14", ras_top); else passed++;
    total++; if (ras_count !== 3'd1) $display("FAIL call_count: got %0d expected 1", ras_count); else passed++;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    total++; if (pc !== 32'h14) $display("FAIL ret_pc: got %h expected 14", pc); else passed++;
    total++; if (ras_count !== 3'd0) $display("FAIL ret_count: got %0d expected 0", ras_count); else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 1; i <= 5; i++) step(0, 1, 32'(16 * i), 1, 0);
    total++; if (ras_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", ras_count); else passed++;
    total++; if (ras_top !== 32'h44) $display("FAIL ovf_top: got %h expected 44", ras_top); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      total++; if (pc !== exp_ret[i]) $display("FAIL ovf_ret_%0d: got %h expected %h", i, pc, exp_ret[i]); else passed++;
      total++; if (ras_count !== 3'(3 - i)) $display("FAIL ovf_cnt_%0d: got %0d expected %0d", i, ras_count, 3 - i); else passed++;
    end
    total++; if (ras_underflow !== 1'b0) $display("FAIL no_underflow: got %b expected 0", ras_underflow); else passed++;
    step(0, 0, 0, 0, 1);
    total++; if (pc !== 32'h18) $display("FAIL underflow_pc: got %h expected 18", pc); else passed++;
    total++; if (ras_underflow !== 1'b1) $display("FAIL underflow_pulse: got %b expected 1", ras_underflow); else passed++;
    step(0, 0, 0, 0, 0);
    total++; if ({pc, ras_underflow} !== {32'h1C, 1'b0}) $display("FAIL underflow_end: got %h/%b expected 1c/0", pc, ras_underflow); else passed++;
  endtask

  task automatic test_call_ret_same;
    step(0, 1, 32'h10, 0, 0);
    step(0, 1, 32'h60, 1, 0);
    total++; if (ras_top !== 32'h14) $display("FAIL same_pre_top: got %h expected 14", ras_top); else passed++;
    step(0, 0, 0, 1, 1);
    total++; if (pc !== 32'h14) $display("FAIL same_pc: got %h expected 14", pc); else passed++;
    total++; if (ras_top !== 32'h64) $display("FAIL same_top: got %h expected 64", ras_top); else passed++;
    total++; if (ras_count !== 3'd1) $display("FAIL same_count: got %0d expected 1", ras_count); else passed++;
    step(0, 0, 0, 0, 1);
    total++; if ({pc, ras_count} !== {32'h64, 3'd0}) $display("FAIL same_ret: got %h/%0d expected 64/0", pc, ras_count); else passed++;
    step(0, 0, 0, 1, 1);
    total++; if ({pc, ras_top, ras_count} !== {32'h68, 32'h68, 3'd1}) $display("FAIL same_empty: got %h/%h/%0d expected 68/68/1", pc, ras_top, ras_count); else passed++;
    total++; if (ras_underflow !== 1'b0) $display("FAIL same_empty_uf: got %b expected 0", ras_underflow); else passed++;
    step(0, 1, 32'h400, 0, 1);
    total++; if ({pc, ras_count} !== {32'h400, 3'd0}) $display("FAIL redirect_pop: got %h/%0d expected 400/0", pc, ras_count); else passed++;
  endtask

  task automatic test_wrap;
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pcp4_pre: got %h expected 0", pc_plus4); else passed++;
    step(0, 0, 0, 0, 0);
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h expected 0", pc); else passed++;
    total++; if (pc_plus4 !== 32'h4) $display("FAIL wrap_pcp4: got %h expected 4", pc_plus4); else passed++;
  endtask

  initial begin
    test_reset();
    test_redirect_stall();
    test_call_ret();
    test_overflow();
    test_call_ret_same();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle RISC-V core, replacing the plain `pc` register. It holds the fetch address and selects the next PC from reset vector, redirect target, stall hold, return-address-stack (RAS) prediction or sequential increment. An internal circular RAS predicts `ret` targets and tracks call depth. It feeds instruction-memory address and the `pc + 4` link value to the datapath.

## Interface
- `XLEN`, 32: PC / address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `RAS_DEPTH`, 4: RAS entries, power of two, 2..16.
- `CW`, $clog2(RAS_DEPTH+1): width of `ras_count` (derived, not overridden).

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC; RAS unchanged.
- `redirect_valid`  in  1  resolved branch/jump/trap redirect this cycle.
- `redirect_target`  in  XLEN  redirect address.
- `call`  in  1  current instruction is a call (link to x1/x5); push `pc + 4`.
- `ret`  in  1  current instruction is a return; pop RAS.
- `pc`  out  XLEN  current fetch address (registered).
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, wraps modulo 2^XLEN.
- `ras_top`  out  XLEN  current RAS top entry (combinational; 0 when empty).
- `ras_count`  out  CW  valid RAS entries, 0..RAS_DEPTH.
- `misalign`  out  1  registered: last accepted redirect target had bits [1:0] ≠ 0.
- `ras_underflow`  out  1  registered one-cycle pulse: `ret` with empty RAS.

## Operation
- One clock domain; reset is asynchronous and active-high on `reset`.
- Reset: `pc` = RESET_VECTOR, `ras_count` = 0, write pointer = 0, all RAS entries = 0, `misalign` = 0, `ras_underflow` = 0. Reset asserted mid-operation overrides everything immediately (asynchronously); first update after deassertion is the first rising edge with `reset` low.
- Next-PC priority (highest first):
  1. `redirect_valid`: `pc` ← `{redirect_target[XLEN-1:2], 2'b00}`; `misalign` ← `|redirect_target[1:0]`. Wins over `stall`.
  2. `stall`: `pc` holds; `misalign` holds.
  3. `ret` and `ras_count` > 0: `pc` ← `ras_top`.
  4. otherwise: `pc` ← `pc_plus4`.
- `misalign` is updated only on redirect cycles; otherwise holds.
- RAS updates only when `stall` = 0 (stall freezes the RAS even if `redirect_valid` = 1):
  - `call` only: write `pc_plus4` at write pointer, pointer +1 (mod RAS_DEPTH), count +1 saturating at RAS_DEPTH. Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - `ret` only, count > 0: pointer −1, count −1; popped entry not cleared.
  - `ret` only, count = 0: RAS unchanged; `ras_underflow` pulses next cycle; PC follows rules 1/4.
  - `call` and `ret` together: top entry replaced by `pc_plus4`; pointer and count unchanged. If count = 0, acts as push (count → 1), no underflow.
- `ras_top` = entry at (pointer − 1) mod RAS_DEPTH when count > 0, else 0.
- Redirect and RAS pop together: RAS pops, PC takes redirect target (redirect is authoritative).
- All arithmetic is unsigned modulo 2^XLEN; `pc` at 32'hFFFF_FFFC increments to 0.

## Timing
- `pc`, `ras_count`, RAS storage, `misalign`, `ras_underflow` update on the rising edge of `clk`.
- `pc_plus4` and `ras_top` are combinational from registered state; zero-cycle latency.
- Redirect latency: target visible on `pc` one cycle after the edge sampling `redirect_valid`.
- `ras_underflow` is high for exactly one cycle after the offending edge.
- No handshake; inputs sampled every non-reset edge; `call`/`ret` ignored while `stall` = 1.

## Test plan
- Reset then free-run: after `reset` falls, `pc` = 0, 4, 8, 12 on successive edges; `ras_count` = 0; assert `reset` mid-run with `pc` = 12 → `pc` = 0 immediately, before next edge.
- Redirect vs stall: `pc` = 8, `stall` = 1 two cycles → `pc` stays 8; `stall` = 1 with `redirect_valid` = 1, target 32'h100 → `pc` = 32'h100, `ras_count` unchanged; target 32'h203 → `pc` = 32'h200, `misalign` = 1.
- Call/return: at `pc` = 32'h10 `call` + redirect 32'h80 → `ras_top` = 32'h14, count 1; at 32'h84 `ret` → `pc` = 32'h14, count 0.
- RAS overflow: five calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 → count 4, `ras_top` = 0x44; four rets return 0x44, 0x34, 0x24, 0x14 (0x04 lost); fifth ret → `ras_underflow` pulse, `pc` = `pc_plus4`.
- Simultaneous `call` + `ret` at `pc` = 32'h60 with `ras_top` = 32'h14 → `pc` = 32'h14, `ras_top` = 32'h64, count unchanged.
- Wrap: redirect to 32'hFFFF_FFFC then one free edge → `pc` = 0, `pc_plus4` = 4.
